tdm_demux16: RTL and testbench

- Receive end of the 16:1 select path: takes a time-division serial bit stream and rebuilds a 16-bit parallel word.
- Slot k of a frame (select code k on the transmit side) is written to dout[k].
- Frame start is marked by a sync strobe.
- Completed words are presented on a valid/ready output register; drop and resync conditions are flagged.

---
 rtl/tdm_demux16.sv | 82 ++++++++
 tb/tb_tdm_demux16.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/tdm_demux16.sv
// tdm_demux16: rebuilds a parallel word from a TDM serial slot stream.
// The word is held in a valid/ready output register; drops and resyncs are flagged.
module tdm_demux16 #(
  parameter int CHANNELS = 16,
  parameter int SEL_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                din,
  input  logic                din_valid,
  input  logic                frame_start,
  input  logic                dout_ready,
  input  logic                overrun_clr,
  output logic [CHANNELS-1:0] dout,
  output logic                dout_valid,
  output logic [SEL_W-1:0]    slot,
  output logic                sync_err,
  output logic                overrun
);
  typedef enum logic {IDLE, COLLECT} state_t;
  state_t              state_q, state_d;
  logic [SEL_W-1:0]    slot_q, slot_d;
  logic [CHANNELS-1:0] buf_q, buf_d;
  logic [CHANNELS-1:0] dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;
  logic                sync_err_q, sync_err_d;
  logic                overrun_q, overrun_d;
  logic                complete, room;
  logic [CHANNELS-1:0] word;
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    buf_d        = buf_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q && !dout_ready;
    sync_err_d   = 1'b0;
    overrun_d    = overrun_clr ? 1'b0 : overrun_q;
    complete     = din_valid && !frame_start && state_q == COLLECT && slot_q == SEL_W'(CHANNELS - 1);
    room         = !dout_valid_q || dout_ready;
    word         = {din, buf_q[CHANNELS-2:0]};
    if (din_valid && frame_start) begin
      // a new frame clears the buffer so an aborted frame leaves no stale bits
      buf_d      = CHANNELS'(din);
      slot_d     = SEL_W'(1);
      state_d    = COLLECT;
      sync_err_d = state_q == COLLECT;
    end else if (din_valid && state_q == COLLECT) begin
      buf_d[slot_q] = din;
      slot_d        = complete ? '0 : slot_q + SEL_W'(1);
      state_d       = complete ? IDLE : COLLECT;
    end
    if (complete && room) begin
      dout_d       = word;
      dout_valid_d = 1'b1;
    end
    if (complete && !room) overrun_d = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      slot_q       <= '0;
      buf_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      buf_q        <= buf_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      sync_err_q   <= sync_err_d;
      overrun_q    <= overrun_d;
    end
  end
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign slot       = slot_q;
  assign sync_err   = sync_err_q;
  assign overrun    = overrun_q;
endmodule

// File: tb/tb_tdm_demux16.sv
// tb_tdm_demux16: directed bench; expected words queue up as frames are sent and are
// compared whenever the DUT hands a word over (dout_valid && dout_ready).
module tb_tdm_demux16;
  logic        clk = 0, rst_n = 0, din = 0, din_valid = 0, frame_start = 0;
  logic        dout_ready = 0, overrun_clr = 0;
  logic [15:0] dout;
  logic        dout_valid, sync_err, overrun;
  logic [3:0]  slot;
  logic [15:0] exp_q[$];
  logic [15:0] w;
  int          checks = 0, errors = 0;

  tdm_demux16 dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .frame_start(frame_start),
    .dout_ready(dout_ready), .overrun_clr(overrun_clr), .dout(dout), .dout_valid(dout_valid),
    .slot(slot), .sync_err(sync_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic d, input logic fs);
    din = d; din_valid = 1; frame_start = fs;
    step();
    din_valid = 0; frame_start = 0; din = 0;
  endtask

  task automatic send(input logic [15:0] word, input logic gap);
    for (int i = 0; i < 16; i++) begin
      beat(word[i], i == 0);
      if (gap) begin
        step();
        chk("gap_slot_hold", 32'(slot), 32'((i + 1) % 16));
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) chk("unexpected_word", 32'(dout), 32'hxxxx_xxxx);
      else chk("scoreboard_word", 32'(dout), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    step(); step();
    chk("rst_dout", 32'(dout), 0);
    chk("rst_valid", 32'(dout_valid), 0);
    chk("rst_slot", 32'(slot), 0);
    chk("rst_sync_err", 32'(sync_err), 0);
    chk("rst_overrun", 32'(overrun), 0);
    rst_n = 1;
    dout_ready = 1;
    step();
    // plain frame, one-cycle latency
    exp_q.push_back(16'hA5C3);
    for (int i = 0; i < 15; i++) beat(w[0] | 1'b0 ? 1'b0 : 1'b0, 1'b0);
    chk("idle_beats_slot", 32'(slot), 0);
    w = 16'hA5C3;
    for (int i = 0; i < 15; i++) beat(w[i], i == 0);
    chk("pre_last_valid", 32'(dout_valid), 0);
    beat(w[15], 0);
    chk("f1_valid", 32'(dout_valid), 1);
    chk("f1_dout", 32'(dout), 32'hA5C3);
    chk("f1_slot", 32'(slot), 0);
    step(); step();
    chk("f1_consumed", 32'(dout_valid), 0);
    // gapped frame
    exp_q.push_back(16'hA5C3);
    send(16'hA5C3, 1);
    step();
    // early sync at slot 9, then 0x0001
    for (int i = 0; i < 9; i++) beat(1'b1, i == 0);
    chk("pre_resync_slot", 32'(slot), 9);
    exp_q.push_back(16'h0001);
    beat(1'b1, 1'b1);
    chk("sync_err_pulse", 32'(sync_err), 1);
    chk("resync_slot", 32'(slot), 1);
    for (int i = 1; i < 16; i++) begin
      beat(1'b0, 1'b0);
      if (i == 1) chk("sync_err_single", 32'(sync_err), 0);
    end
    chk("resync_dout", 32'(dout), 32'h0001);
    chk("resync_valid", 32'(dout_valid), 1);
    step(); step();
    // full output register with overrun
    dout_ready = 0;
    exp_q.push_back(16'h1234);
    send(16'h1234, 0);
    chk("held_dout", 32'(dout), 32'h1234);
    send(16'h5678, 0);
    chk("overrun_set", 32'(overrun), 1);
    chk("held_dout_after_drop", 32'(dout), 32'h1234);
    chk("held_valid", 32'(dout_valid), 1);
    overrun_clr = 1;
    step();
    overrun_clr = 0;
    chk("overrun_clr", 32'(overrun), 0);
    dout_ready = 1;
    step();
    chk("drain_valid", 32'(dout_valid), 0);
    // back-to-back transfer with no bubble
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h0000);
    dout_ready = 0;
    send(16'hFFFF, 0);
    chk("b2b_first", 32'(dout), 32'hFFFF);
    for (int i = 0; i < 15; i++) beat(1'b0, i == 0);
    dout_ready = 1;
    beat(1'b0, 1'b0);
    chk("b2b_valid", 32'(dout_valid), 1);
    chk("b2b_second", 32'(dout), 32'h0000);
    chk("b2b_overrun", 32'(overrun), 0);
    step(); step();
    // reset mid-frame
    for (int i = 0; i < 7; i++) beat(1'b1, i == 0);
    chk("pre_rst_slot", 32'(slot), 7);
    rst_n = 0;
    step();
    rst_n = 1;
    chk("mid_rst_slot", 32'(slot), 0);
    chk("mid_rst_dout", 32'(dout), 0);
    chk("mid_rst_valid", 32'(dout_valid), 0);
    for (int i = 0; i < 5; i++) beat(1'b1, 1'b0);
    chk("post_rst_ignored_slot", 32'(slot), 0);
    chk("post_rst_ignored_valid", 32'(dout_valid), 0);
    exp_q.push_back(16'hBEEF);
    send(16'hBEEF, 0);
    chk("post_rst_dout", 32'(dout), 32'hBEEF);
    step(); step(); step();
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
